// File: rtl/spi_pkg.sv
// Shared types and defaults for the synchronous SPI slave.
package spi_pkg;

  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    ACTIVE = ST_ACTIVE
  } spi_state_t;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  // Mode number is {cpol, cpha}.
  function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser with registered rise/fall pulses of the synchronised level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely in the clk domain: oversampled SCK/SS/MOSI, run-time mode,
// one-word TX holding buffer, multi-word bursts, overrun/underrun pulses.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   SS,
  input  logic                   SCK,
  input  logic                   MOSI,
  output logic                   MISO,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic                   underrun,
  output spi_state_t             dbg_state
);

  localparam int CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

  logic sck_level_unused;
  logic sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  // SCK level itself is not needed; only its edges are.
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCK),
    .q_o    (sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SS),
    .q_o    (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_state_t             state_q, state_d;
  spi_mode_t              mode_q, mode_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_LENGTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_LENGTH-1:0] buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  logic cpol_q, cpha_q;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic do_load;
  logic [DATA_LENGTH-1:0] rx_word, tx_next;
  logic tx_bit;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cpol_q = mode_q[1];
  assign cpha_q = mode_q[0];

  assign lead_edge   = cpol_q ? sck_fall : sck_rise;
  assign trail_edge  = cpol_q ? sck_rise : sck_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign rx_word = MSB_FIRST ? {rx_shift_q[DATA_LENGTH-2:0], mosi_s}
                             : {mosi_s, rx_shift_q[DATA_LENGTH-1:1]};
  assign tx_next = MSB_FIRST ? {tx_shift_q[DATA_LENGTH-2:0], 1'b0}
                             : {1'b0, tx_shift_q[DATA_LENGTH-1:1]};
  assign tx_bit  = MSB_FIRST ? tx_shift_q[DATA_LENGTH-1] : tx_shift_q[0];

  // Handshakes: a word moves on any clk edge where valid && ready are both high.
  // TX: tx_ready = holding buffer empty. RX: rx_valid holds until a cycle with rx_ready.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    do_load    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = ACTIVE;
        mode_d  = spi_mode(cpol, cpha);
        cnt_d   = '0;
        do_load = ~cpha;
      end
    end else if (ss_rise) begin
      state_d    = IDLE;
      cnt_d      = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else if (sample_edge) begin
      rx_shift_d = rx_word;
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        do_load = ~cpha_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (shift_edge) begin
      // At bit 0 the shifter already holds a fresh word (cpha=0) or must fetch one (cpha=1).
      if (cnt_q == '0) do_load = cpha_q;
      else             tx_shift_d = tx_next;
    end

    if (do_load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // Written after the load decision, so a same-cycle write is never bypassed.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign busy      = (state_q == ACTIVE) && !ss_s;
  assign MISO      = busy & tx_bit;
  assign tx_ready  = ~buf_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;
  assign dbg_state = state_q;

endmodule
